// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the system-bus arbiter.
// Holds the arbiter state encoding, default bus widths and the rotate-priority picker.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WARN  = 2'd1,
        STEAL = 2'd2
    } arb_state_e;

    localparam int unsigned DEF_AW  = 16;
    localparam int unsigned DEF_DW  = 8;
    localparam int unsigned MAX_DMA = 8;
    localparam int unsigned PTR_W   = 3;

    // One-hot pick of the first set request at or after ptr, wrapping at n.
    function automatic logic [MAX_DMA-1:0] rotate_select(
        input logic [MAX_DMA-1:0] req,
        input logic [PTR_W-1:0]   ptr,
        input int unsigned        n
    );
        logic [MAX_DMA-1:0] pick;
        logic [PTR_W-1:0]   k;
        pick = '0;
        for (int unsigned i = 0; i < MAX_DMA; i++) begin
            k = PTR_W'((32'(ptr) + i) % n);
            if (i < n && pick == '0 && req[k]) begin
                pick[k] = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/bus_arb_select.sv
// Combinational request picker: one-hot winner and its index, searching from ptr_i.
module bus_arb_select
    import bus_arb_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  onehot_c,
    output logic [IW-1:0] idx_c,
    output logic          any_c
);

    logic [MAX_DMA-1:0] sel_full;
    logic               unused_hi;

    always_comb begin
        sel_full = rotate_select(MAX_DMA'(req_i), PTR_W'(ptr_i), N);
        onehot_c = sel_full[N-1:0];
        idx_c    = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (onehot_c[i]) begin
                idx_c = IW'(i);
            end
        end
        any_c = |req_i;
    end

    assign unused_hi = ^sel_full;

endmodule

// File: rtl/bus_arbiter.sv
// System-bus arbiter: phi2 generation, CPU ba/aec handshake and DMA master steering.
// Define BUS_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned AW      = DEF_AW,
    parameter int unsigned DW      = DEF_DW,
    parameter int unsigned NUM_DMA = 2,
    parameter int unsigned HALF    = 4,
    parameter int unsigned BA_LEAD = 3
) (
    input  logic                  dot_clk,
    input  logic                  reset,
    input  logic [AW-1:0]         cpu_address,
    input  logic                  cpu_we,
    input  logic [DW-1:0]         cpu_do,
    input  logic [NUM_DMA-1:0]    dma_req,
    input  logic [NUM_DMA*AW-1:0] dma_addr,
    input  logic [NUM_DMA-1:0]    dma_we,
    input  logic [NUM_DMA*DW-1:0] dma_di,
    output logic [NUM_DMA-1:0]    dma_grant,
    output logic                  phi2,
    output logic                  ba,
    output logic                  aec,
    output logic [AW-1:0]         bus_address,
    output logic                  bus_we,
    output logic [DW-1:0]         bus_di
);

    localparam int unsigned CYC       = 2 * HALF;
    localparam int unsigned CNT_W     = $clog2(CYC);
    localparam int unsigned IDX_W     = (NUM_DMA > 1) ? $clog2(NUM_DMA) : 1;
    localparam int unsigned WARN_W    = (BA_LEAD > 1) ? $clog2(BA_LEAD) : 1;
    localparam int unsigned WARN_INIT = (BA_LEAD > 0) ? BA_LEAD - 1 : 0;

    arb_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                phi2_q, phi2_d;
    logic                ba_q, ba_d;
    logic                aec_q, aec_d;
    logic [NUM_DMA-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]    winner_q, winner_d;
    logic [WARN_W-1:0]   warn_q, warn_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic                we_q, we_d;
    logic [DW-1:0]       di_q, di_d;

    logic                boundary;
    logic                issue;
    logic [IDX_W-1:0]    issue_idx;
    logic [NUM_DMA-1:0]  issue_oh;
    logic                src_we;
    logic [IDX_W-1:0]    sel_ptr;
    logic [NUM_DMA-1:0]  sel_onehot;
    logic [IDX_W-1:0]    sel_idx;
    logic                sel_any;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    assign sel_ptr = rr_ptr_q;
`else
    assign sel_ptr = '0;
`endif

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] w);
        return (w == IDX_W'(NUM_DMA - 1)) ? '0 : w + IDX_W'(1);
    endfunction

    bus_arb_select #(.N(NUM_DMA), .IW(IDX_W)) u_select (
        .req_i    (dma_req),
        .ptr_i    (sel_ptr),
        .onehot_c (sel_onehot),
        .idx_c    (sel_idx),
        .any_c    (sel_any)
    );

    assign boundary = (cnt_q == CNT_W'(CYC - 1));

    // Phase counter, ownership FSM and registered bus mux next-state.
    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        warn_d    = warn_q;
        ba_d      = ba_q;
        aec_d     = aec_q;
        grant_d   = grant_q;
        issue     = 1'b0;
        issue_idx = winner_q;
        issue_oh  = grant_q;
        src_we    = 1'b0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
        rr_ptr_d  = rr_ptr_q;
`endif
        cnt_d  = boundary ? '0 : cnt_q + CNT_W'(1);
        phi2_d = (cnt_d >= CNT_W'(HALF));

        if (boundary) begin
            case (state_q)
                IDLE: begin
                    if (sel_any) begin
                        ba_d     = 1'b1;
                        winner_d = sel_idx;
                        if (BA_LEAD == 0) begin
                            issue     = 1'b1;
                            issue_idx = sel_idx;
                            issue_oh  = sel_onehot;
                        end else begin
                            state_d = WARN;
                            warn_d  = WARN_W'(WARN_INIT);
                        end
                    end
                end
                WARN: begin
                    if (!dma_req[winner_q]) begin
                        state_d = IDLE;
                        ba_d    = 1'b0;
                    end else if (warn_q == '0) begin
                        issue     = 1'b1;
                        issue_idx = winner_q;
                        issue_oh  = NUM_DMA'(1) << winner_q;
                    end else begin
                        warn_d = warn_q - WARN_W'(1);
                    end
                end
                STEAL: begin
                    // Handover to another pending master skips the warning period.
                    if (!dma_req[winner_q]) begin
                        if (sel_any) begin
                            issue     = 1'b1;
                            issue_idx = sel_idx;
                            issue_oh  = sel_onehot;
                        end else begin
                            state_d = IDLE;
                            ba_d    = 1'b0;
                            aec_d   = 1'b1;
                            grant_d = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (issue) begin
            state_d  = STEAL;
            winner_d = issue_idx;
            ba_d     = 1'b1;
            aec_d    = 1'b0;
            grant_d  = issue_oh;
`ifdef BUS_ARB_ROUND_ROBIN_EN
            rr_ptr_d = next_idx(issue_idx);
`endif
        end

        addr_d = cpu_address;
        di_d   = cpu_do;
        src_we = cpu_we;
        if (!aec_q) begin
            for (int k = 0; k < int'(NUM_DMA); k++) begin
                if (IDX_W'(k) == winner_q) begin
                    addr_d = dma_addr[k*AW +: AW];
                    di_d   = dma_di[k*DW +: DW];
                    src_we = dma_we[k];
                end
            end
        end
        // The phi1 half belongs to VIC reads, so writes are confined to phi2-high.
        we_d = phi2_d & src_we;
    end

    always_ff @(posedge dot_clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            phi2_q   <= 1'b0;
            ba_q     <= 1'b0;
            aec_q    <= 1'b1;
            grant_q  <= '0;
            winner_q <= '0;
            warn_q   <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            di_q     <= '0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            phi2_q   <= phi2_d;
            ba_q     <= ba_d;
            aec_q    <= aec_d;
            grant_q  <= grant_d;
            winner_q <= winner_d;
            warn_q   <= warn_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            di_q     <= di_d;
`ifdef BUS_ARB_ROUND_ROBIN_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    assign dma_grant   = grant_q;
    assign phi2        = phi2_q;
    assign ba          = ba_q;
    assign aec         = aec_q;
    assign bus_address = addr_q;
    assign bus_we      = we_q;
    assign bus_di      = di_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter against a bus-cycle level ownership model.
module tb_bus_arbiter;

    localparam int AW      = 16;
    localparam int DW      = 8;
    localparam int N       = 2;
    localparam int HALF    = 4;
    localparam int BA_LEAD = 3;
    localparam int CYC     = 2 * HALF;

    logic            dot_clk;
    logic            reset;
    logic [AW-1:0]   cpu_address;
    logic            cpu_we;
    logic [DW-1:0]   cpu_do;
    logic [N-1:0]    dma_req;
    logic [N*AW-1:0] dma_addr;
    logic [N-1:0]    dma_we;
    logic [N*DW-1:0] dma_di;
    logic [N-1:0]    dma_grant;
    logic            phi2;
    logic            ba;
    logic            aec;
    logic [AW-1:0]   bus_address;
    logic            bus_we;
    logic [DW-1:0]   bus_di;

    bus_arbiter #(.AW(AW), .DW(DW), .NUM_DMA(N), .HALF(HALF), .BA_LEAD(BA_LEAD)) dut (
        .dot_clk     (dot_clk),
        .reset       (reset),
        .cpu_address (cpu_address),
        .cpu_we      (cpu_we),
        .cpu_do      (cpu_do),
        .dma_req     (dma_req),
        .dma_addr    (dma_addr),
        .dma_we      (dma_we),
        .dma_di      (dma_di),
        .dma_grant   (dma_grant),
        .phi2        (phi2),
        .ba          (ba),
        .aec         (aec),
        .bus_address (bus_address),
        .bus_we      (bus_we),
        .bus_di      (bus_di)
    );

    initial dot_clk = 1'b0;
    always #5 dot_clk = ~dot_clk;

    int total = 0;
    int bad   = 0;

    // Model: position within the bus cycle, current bus owner, warned candidate.
    int m_phase = 0;
    int m_owner = -1;
    int m_cand  = -1;
    int m_warn  = 0;
    int m_rr    = 0;
    logic [AW-1:0] e_addr = '0;
    logic          e_we   = 1'b0;
    logic [DW-1:0] e_di   = '0;
    bit hold_we = 1'b0;

    int t_ba, t_aec, nseq, prio_exp;
    logic [N-1:0] gseen, last_g;
    logic [N-1:0] seq [3];

    function automatic bit req_bit(input int k);
        return ((dma_req >> k) & N'(1)) != '0;
    endfunction

    function automatic int pick(input logic [N-1:0] r, input int start);
        for (int i = 0; i < N; i++) begin
            int k;
            k = (start + i) % N;
            if (((r >> k) & N'(1)) != '0) return k;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [AW-1:0] sa;
        logic          sw;
        logic [DW-1:0] sd;
        int nw, start;
        if (reset) begin
            m_phase = 0; m_owner = -1; m_cand = -1; m_warn = 0; m_rr = 0;
            e_addr = '0; e_we = 1'b0; e_di = '0;
            return;
        end
        if (m_owner < 0) begin
            sa = cpu_address; sw = cpu_we; sd = cpu_do;
        end else begin
            sa = AW'(dma_addr >> (m_owner * AW));
            sw = ((dma_we >> m_owner) & N'(1)) != '0;
            sd = DW'(dma_di >> (m_owner * DW));
        end
`ifdef BUS_ARB_ROUND_ROBIN_EN
        start = m_rr;
`else
        start = 0;
`endif
        if (m_phase == CYC - 1) begin
            nw = pick(dma_req, start);
            if (m_owner >= 0) begin
                if (!req_bit(m_owner)) begin
                    m_owner = nw;
                    if (nw >= 0) m_rr = (nw + 1) % N;
                end
            end else if (m_cand >= 0) begin
                if (!req_bit(m_cand)) m_cand = -1;
                else if (m_warn == 0) begin
                    m_owner = m_cand; m_rr = (m_cand + 1) % N; m_cand = -1;
                end else m_warn--;
            end else if (nw >= 0) begin
                if (BA_LEAD == 0) begin
                    m_owner = nw; m_rr = (nw + 1) % N;
                end else begin
                    m_cand = nw; m_warn = BA_LEAD - 1;
                end
            end
        end
        m_phase = (m_phase + 1) % CYC;
        e_addr = sa;
        e_we   = sw && (m_phase >= HALF);
        e_di   = sd;
    endtask

    task automatic check_all();
        chk("phi2",  32'(phi2),        32'(m_phase >= HALF));
        chk("ba",    32'(ba),          32'(m_owner >= 0 || m_cand >= 0));
        chk("aec",   32'(aec),         32'(m_owner < 0));
        chk("grant", 32'(dma_grant),   (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("addr",  32'(bus_address), 32'(e_addr));
        chk("we",    32'(bus_we),      32'(e_we));
        chk("di",    32'(bus_di),      32'(e_di));
    endtask

    task automatic rand_bus();
        cpu_address = AW'($urandom);
        cpu_we      = 1'($urandom);
        cpu_do      = DW'($urandom);
        dma_addr    = (N*AW)'({$urandom, $urandom});
        dma_di      = (N*DW)'($urandom);
        dma_we      = hold_we ? '1 : N'($urandom);
    endtask

    task automatic tick();
        @(posedge dot_clk);
        model_edge();
        #1;
        check_all();
        rand_bus();
    endtask

    task automatic align();
        for (int i = 0; i < CYC && m_phase != 0; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        dma_req = '0;
        rand_bus();
        tick();
        tick();
        chk("rst_aec",   32'(aec), 32'd1);
        chk("rst_ba",    32'(ba), 32'd0);
        chk("rst_phi2",  32'(phi2), 32'd0);
        chk("rst_grant", 32'(dma_grant), 32'd0);
        reset = 1'b0;

        // Idle bus cycles: CPU owns the bus.
        repeat (4 * CYC) tick();

        // Master 0 request: ba lead time before aec drops.
        align();
        dma_req = 2'b01;
        t_ba = -1; t_aec = -1;
        for (int i = 0; i < 8 * CYC && t_aec < 0; i++) begin
            tick();
            if (ba === 1'b1 && t_ba < 0) t_ba = i;
            if (aec === 1'b0 && t_aec < 0) t_aec = i;
        end
        chk("ba_lead", 32'(t_aec - t_ba), 32'(BA_LEAD * CYC));
        chk("grant0",  32'(dma_grant), 32'd1);

        // Handover 0 -> 1 inside STEAL without a new warning.
        tick(); tick();
        dma_req = 2'b10;
        repeat (CYC) tick();
        chk("handover_grant", 32'(dma_grant), 32'd2);
        chk("handover_aec",   32'(aec), 32'd0);
        chk("handover_ba",    32'(ba), 32'd1);
        dma_req = 2'b00;
        repeat (2 * CYC) tick();
        chk("release_aec", 32'(aec), 32'd1);
        chk("release_ba",  32'(ba), 32'd0);

        // One-cycle request pulse is withdrawn during WARN.
        align();
        gseen = '0;
        dma_req = 2'b10;
        repeat (CYC) begin tick(); gseen |= dma_grant; end
        dma_req = 2'b00;
        repeat (3 * CYC) begin tick(); gseen |= dma_grant; end
        chk("pulse_nogrant", 32'(gseen), 32'd0);
        chk("pulse_ba",      32'(ba), 32'd0);

        // Both masters requesting, each releasing after one granted cycle.
        dma_req = 2'b11;
        nseq = 0;
        last_g = '0;
        for (int i = 0; i < 3; i++) seq[i] = '0;
        for (int i = 0; i < 30 * CYC && nseq < 3; i++) begin
            tick();
            if (dma_grant != last_g && dma_grant != '0) begin
                seq[nseq] = dma_grant;
                nseq++;
            end
            last_g = dma_grant;
            for (int k = 0; k < N; k++) begin
                if (m_owner == k && m_phase == HALF) dma_req = dma_req & ~(N'(1) << k);
                else if (m_owner != k && !req_bit(k)) dma_req = dma_req | (N'(1) << k);
            end
        end
        chk("alt0", 32'(seq[0]), 32'd1);
        chk("alt1", 32'(seq[1]), 32'd2);
        chk("alt2", 32'(seq[2]), 32'd1);
        dma_req = 2'b00;
        repeat (3 * CYC) tick();

        // Simultaneous fresh request from both masters after master 0 was served last.
        dma_req = 2'b11;
        for (int i = 0; i < 8 * CYC && aec !== 1'b0; i++) tick();
`ifdef BUS_ARB_ROUND_ROBIN_EN
        prio_exp = 2;
`else
        prio_exp = 1;
`endif
        chk("prio_pick", 32'(dma_grant), 32'(prio_exp));
        dma_req = 2'b00;
        repeat (2 * CYC) tick();

        // Randomized request traffic.
        repeat (60 * CYC) begin
            tick();
            if ($urandom_range(0, 9) == 0) dma_req = dma_req ^ (N'(1) << $urandom_range(0, N - 1));
        end
        dma_req = 2'b00;
        repeat (2 * CYC) tick();

        // Reset during STEAL with a master writing.
        dma_req = 2'b01;
        for (int i = 0; i < 8 * CYC && aec !== 1'b0; i++) tick();
        repeat (HALF) tick();
        hold_we = 1'b1;
        rand_bus();
        reset = 1'b1;
        tick();
        chk("rst_steal_aec",   32'(aec), 32'd1);
        chk("rst_steal_ba",    32'(ba), 32'd0);
        chk("rst_steal_grant", 32'(dma_grant), 32'd0);
        chk("rst_steal_we",    32'(bus_we), 32'd0);
        reset   = 1'b0;
        hold_we = 1'b0;
        dma_req = 2'b00;
        repeat (2 * CYC) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
